mux_arb_stream: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer with a registered output stage and valid/ready handshakes on every port. It replaces the combinational 4:1 2-bit select mux in datapaths where sources are bursty and the sink can stall. Channel choice is manual (select port), fixed-priority or round-robin, chosen at run time. It sits between multiple producer streams and a single consumer.

---
 rtl/mux_arb_pkg.sv | 11 +
 rtl/mux_arb_stream_rr_pick.sv | 30 +++
 rtl/mux_arb_stream.sv | 138 +++++++++++++
 tb/tb_mux_arb_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_arb_stream arbiter: arbitration mode encoding.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_FIXED  = 2'b01,
      MODE_RR     = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

endpackage

// File: rtl/mux_arb_stream_rr_pick.sv
// Rotating priority picker: first set request at or after 'start', wrapping at N_CH-1.
module rr_pick #(
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] start,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int i = 0; i < N_CH; i++) begin
         j = int'(start) + i;
         if (j >= N_CH) j = j - N_CH;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = SEL_W'(j);
         end
      end
   end

endmodule

// File: rtl/mux_arb_stream.sv
// N-channel registered stream mux with manual / fixed-priority / round-robin arbitration.
// Optional packet lock (grant held until in_last) enabled by defining MUX_ARB_PKT_LOCK_EN.
module mux_arb_stream
   import mux_arb_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int WIDTH = 2,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH-1:0]       in_last,
   output logic [N_CH-1:0]       in_ready,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      select,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_sel
);

   logic             load_en, xfer;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic [N_CH-1:0]  fix_gnt, rr_gnt, gnt_vec;
   logic [SEL_W-1:0] fix_idx, rr_idx, gnt_idx;
   logic             fix_any, rr_any, gnt_any;

`ifdef MUX_ARB_PKT_LOCK_EN
   logic             lock_q, lock_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
`else
   logic             unused_last;
   assign unused_last = ^in_last;
`endif

   rr_pick #(.N_CH(N_CH)) u_fix (
      .req(in_valid), .start('0), .gnt(fix_gnt), .idx(fix_idx), .any(fix_any)
   );

   rr_pick #(.N_CH(N_CH)) u_rr (
      .req(in_valid), .start(ptr_q), .gnt(rr_gnt), .idx(rr_idx), .any(rr_any)
   );

   always_comb begin
      gnt_vec = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
`ifdef MUX_ARB_PKT_LOCK_EN
      // An open packet owns the output regardless of mode/select.
      if (lock_q) begin
         gnt_idx = lock_ch_q;
         gnt_any = in_valid[lock_ch_q];
         gnt_vec = gnt_any ? (N_CH'(1) << lock_ch_q) : '0;
      end else
`endif
      begin
         case (mode_e'(mode))
            MODE_MANUAL: begin
               if (int'(select) < N_CH && in_valid[select]) begin
                  gnt_idx = select;
                  gnt_any = 1'b1;
                  gnt_vec = N_CH'(1) << select;
               end
            end
            MODE_RR: begin
               gnt_idx = rr_idx;
               gnt_any = rr_any;
               gnt_vec = rr_gnt;
            end
            default: begin
               gnt_idx = fix_idx;
               gnt_any = fix_any;
               gnt_vec = fix_gnt;
            end
         endcase
      end
   end

   assign load_en  = !out_valid_q || out_ready;
   assign xfer     = load_en && gnt_any;
   assign in_ready = (xfer && !rst) ? gnt_vec : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
`ifdef MUX_ARB_PKT_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
`endif
      if (load_en) begin
         out_valid_d = gnt_any;
         if (gnt_any) begin
            out_data_d = in_data[gnt_idx*WIDTH +: WIDTH];
            out_sel_d  = gnt_idx;
            ptr_d      = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
`ifdef MUX_ARB_PKT_LOCK_EN
            lock_d     = !in_last[gnt_idx];
            lock_ch_d  = gnt_idx;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
`ifdef MUX_ARB_PKT_LOCK_EN
         lock_q      <= 1'b0;
         lock_ch_q   <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
`ifdef MUX_ARB_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_stream.sv
// Bench for mux_arb_stream: vector table, backpressure/reset/lock sequences, random vs. model.
module tb_mux_arb_stream;

   localparam int N_CH  = 4;
   localparam int WIDTH = 2;
   localparam int SEL_W = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid, in_last, in_ready;
   logic [1:0]            mode;
   logic [SEL_W-1:0]      select;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid, out_ready;
   logic [SEL_W-1:0]      out_sel;

   always #5 clk = ~clk;

   mux_arb_stream #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .mode(mode), .select(select), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit               m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_sel, m_ptr, m_lock_ch;
   bit               m_lock;

   typedef struct {
      logic [1:0] mode;
      logic [1:0] sel;
      logic [3:0] valid;
      logic       ordy;
      logic       exp_v;
      logic [1:0] exp_sel;
      logic [1:0] exp_data;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant();
      if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
      if (mode == 2'b00) return (int'(select) < N_CH && in_valid[select]) ? int'(select) : -1;
      if (mode == 2'b10) begin
         for (int k = 0; k < N_CH; k++)
            if (in_valid[(m_ptr + k) % N_CH]) return (m_ptr + k) % N_CH;
         return -1;
      end
      for (int k = 0; k < N_CH; k++)
         if (in_valid[k]) return k;
      return -1;
   endfunction

   function automatic logic [N_CH-1:0] model_ready();
      int g;
      g = model_grant();
      if ((!m_valid || out_ready) && g >= 0) return N_CH'(1) << g;
      return '0;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
   endtask

   // One clock: check in_ready before the edge, advance model, check outputs after it.
   task automatic cycle(input string tag);
      int g;
      bit le;
      #1;
      check({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
      g  = model_grant();
      le = !m_valid || out_ready;
      @(posedge clk);
      if (le) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_sel   = g;
            m_ptr   = (g + 1) % N_CH;
`ifdef MUX_ARB_PKT_LOCK_EN
            m_lock    = !in_last[g];
            m_lock_ch = g;
`endif
         end else begin
            m_valid = 0;
         end
      end
      #1;
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".out_data"}, 32'(out_data), 32'(m_data));
      check({tag, ".out_sel"}, 32'(out_sel), 32'(m_sel));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl.push_back('{2'b00, 2'd0, 4'b1111, 1'b1, 1'b1, 2'd0, 2'b10});
      tbl.push_back('{2'b00, 2'd1, 4'b1111, 1'b1, 1'b1, 2'd1, 2'b00});
      tbl.push_back('{2'b00, 2'd2, 4'b1111, 1'b1, 1'b1, 2'd2, 2'b01});
      tbl.push_back('{2'b00, 2'd3, 4'b1111, 1'b1, 1'b1, 2'd3, 2'b11});
      tbl.push_back('{2'b00, 2'd2, 4'b1011, 1'b1, 1'b0, 2'd3, 2'b11});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{2'b01, 2'd0, 4'b1110, 1'b1, 1'b1, 2'd1, 2'b00});
      tbl.push_back('{2'b11, 2'd0, 4'b1100, 1'b1, 1'b1, 2'd2, 2'b01});
      tbl.push_back('{2'b10, 2'd0, 4'b1000, 1'b1, 1'b1, 2'd3, 2'b11});
      tbl.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 1'b1, 2'd0, 2'b10});
      tbl.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 1'b1, 2'd1, 2'b00});
      tbl.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 1'b1, 2'd2, 2'b01});
      tbl.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 1'b1, 2'd3, 2'b11});
      tbl.push_back('{2'b10, 2'd0, 4'b1111, 1'b1, 1'b1, 2'd0, 2'b10});
      for (int i = 0; i < 2; i++) begin
         tbl.push_back('{2'b10, 2'd0, 4'b1001, 1'b1, 1'b1, 2'd3, 2'b11});
         tbl.push_back('{2'b10, 2'd0, 4'b1001, 1'b1, 1'b1, 2'd0, 2'b10});
      end

      // Power-on reset with all channels requesting: in_ready must stay low.
      rst = 1'b1;
      in_data = 8'b11_01_00_10;
      in_valid = 4'b1111; in_last = '0; mode = 2'b00; select = '0; out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.out_valid", 32'(out_valid), 0);
      check("reset.out_data", 32'(out_data), 0);
      check("reset.out_sel", 32'(out_sel), 0);
      check("reset.in_ready", 32'(in_ready), 0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         mode = tbl[i].mode; select = tbl[i].sel;
         in_valid = tbl[i].valid; out_ready = tbl[i].ordy;
         cycle("tbl");
         check($sformatf("tbl[%0d].out_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
         check($sformatf("tbl[%0d].out_sel", i), 32'(out_sel), 32'(tbl[i].exp_sel));
         check($sformatf("tbl[%0d].out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      end

      // Backpressure: hold a beat for 3 stalled cycles, then drain and reload together.
      mode = 2'b00; select = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
      cycle("bp.load");
      select = 2'd2; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle("bp.stall");
         check("bp.stall.in_ready", 32'(in_ready), 0);
         check("bp.stall.out_data", 32'(out_data), 32'(2'b00));
         check("bp.stall.out_sel", 32'(out_sel), 1);
      end
      out_ready = 1'b1;
      #1;
      check("bp.release.in_ready", 32'(in_ready), 32'(4'b0100));
      cycle("bp.release");
      check("bp.release.out_data", 32'(out_data), 32'(2'b01));
      check("bp.release.out_valid", 32'(out_valid), 1);

      // Asynchronous reset between edges discards the held beat at once.
      rst = 1'b1;
      #1;
      check("midrst.out_valid", 32'(out_valid), 0);
      check("midrst.out_data", 32'(out_data), 0);
      check("midrst.out_sel", 32'(out_sel), 0);
      check("midrst.in_ready", 32'(in_ready), 0);
      model_reset();
      @(posedge clk);
      #1;
      check("midrst.hold.in_ready", 32'(in_ready), 0);
      rst = 1'b0;

`ifdef MUX_ARB_PKT_LOCK_EN
      // Packet of 3 beats on channel 1 must not interleave with channel 2.
      mode = 2'b10; in_valid = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         in_last = (i == 2) ? 4'b0010 : 4'b0000;
         cycle("lock");
         check($sformatf("lock[%0d].out_sel", i), 32'(out_sel), (i < 3) ? 1 : 2);
      end
      in_last = '0;
`endif

      for (int i = 0; i < 400; i++) begin
         in_data   = N_CH*WIDTH'($urandom);
         in_valid  = N_CH'($urandom);
         in_last   = N_CH'($urandom);
         mode      = 2'($urandom);
         select    = SEL_W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
